// File: rtl/cpu_dmem_if.sv
// cpu_dmem_if: single-outstanding data-memory bus interface with timeout for the memory stage
module cpu_dmem_if #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_cpu_request,
  input  logic [31:0] i_cpu_address,
  input  logic        i_cpu_write,
  input  logic [3:0]  i_cpu_wstrb,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_valid,
  output logic        o_cpu_mem_busy,
  output logic        o_bus_req,
  input  logic        i_bus_ack,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_write,
  output logic [3:0]  o_bus_wstrb,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_timeout,
  output logic        o_err_overrun
);
  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;
  localparam logic [15:0] TO = 16'(TIMEOUT);
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_write;
  logic        r_valid;
  logic        r_busy;
  logic        r_req;
  logic        r_timeout;
  logic        r_overrun;
  logic        w_expired;
  logic [15:0] w_cnt_inc;
  assign w_expired = (r_cnt == TO);
  assign w_cnt_inc = w_expired ? r_cnt : r_cnt + 16'd1;
  assign o_cpu_rdata    = r_rdata;
  assign o_cpu_valid    = r_valid;
  assign o_cpu_mem_busy = r_busy;
  assign o_bus_req      = r_req;
  assign o_bus_addr     = r_addr;
  assign o_bus_write    = r_write;
  assign o_bus_wstrb    = r_wstrb;
  assign o_bus_wdata    = r_wdata;
  assign o_bus_timeout  = r_timeout;
  assign o_err_overrun  = r_overrun;
  // access FSM: capture, hold request until ack, wait for data, pulse completion; all outputs registered
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_write   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_req     <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (i_cpu_request && r_state != IDLE)
        r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (i_cpu_request) begin
          r_addr  <= {i_cpu_address[31:2], 2'b00};
          r_write <= i_cpu_write;
          r_wstrb <= i_cpu_wstrb;
          r_wdata <= i_cpu_wdata;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          if (i_cpu_write && i_cpu_wstrb == 4'b0000) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end else begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: if (i_bus_ack) begin
          r_req <= 1'b0;
          if (r_write || i_bus_rvalid) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            if (!r_write)
              r_rdata <= i_bus_rdata;
          end else begin
            r_state <= RWAIT;
            r_cnt   <= w_cnt_inc;
          end
        end else if (w_expired) begin
          r_req     <= 1'b0;
          r_state   <= DONE;
          r_valid   <= 1'b1;
          r_timeout <= 1'b1;
          if (!r_write)
            r_rdata <= ERR_DATA;
        end else begin
          r_cnt <= w_cnt_inc;
        end
        RWAIT: if (i_bus_rvalid) begin
          r_rdata <= i_bus_rdata;
          r_state <= DONE;
          r_valid <= 1'b1;
        end else if (w_expired) begin
          r_rdata   <= ERR_DATA;
          r_state   <= DONE;
          r_valid   <= 1'b1;
          r_timeout <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_dmem_if.sv
// tb_cpu_dmem_if: directed scenario tests for cpu_dmem_if
module tb_cpu_dmem_if;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_request = 1'b0;
  logic [31:0] cpu_address = '0;
  logic        cpu_write = 1'b0;
  logic [3:0]  cpu_wstrb = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_mem_busy;
  logic        bus_req;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_timeout;
  logic        err_overrun;
  int errors = 0;
  int checks = 0;

  cpu_dmem_if #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_cpu_request(cpu_request), .i_cpu_address(cpu_address), .i_cpu_write(cpu_write),
    .i_cpu_wstrb(cpu_wstrb), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_valid(cpu_valid), .o_cpu_mem_busy(cpu_mem_busy),
    .o_bus_req(bus_req), .i_bus_ack(bus_ack), .o_bus_addr(bus_addr), .o_bus_write(bus_write),
    .o_bus_wstrb(bus_wstrb), .o_bus_wdata(bus_wdata), .i_bus_rvalid(bus_rvalid),
    .i_bus_rdata(bus_rdata), .o_bus_timeout(bus_timeout), .o_err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    cpu_request = 1'b1; cpu_address = a; cpu_write = w; cpu_wstrb = s; cpu_wdata = d;
    tick();
    cpu_request = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (cpu_mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", cpu_mem_busy); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cpu_valid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if ({bus_addr, bus_wdata, bus_wstrb, bus_write, bus_timeout, err_overrun} !== 71'h0) begin
      errors++; $display("FAIL reset_bus_regs got=%h/%h/%b/%b/%b/%b exp=all zero", bus_addr, bus_wdata, bus_wstrb, bus_write, bus_timeout, err_overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load;
    issue(32'h0000_1004, 1'b0, 4'b0000, 32'h0);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL load_bus_req got=%b exp=1", bus_req); end
    checks++; if (bus_addr !== 32'h0000_1004) begin errors++; $display("FAIL load_bus_addr got=%h exp=00001004", bus_addr); end
    checks++; if (bus_write !== 1'b0) begin errors++; $display("FAIL load_bus_write got=%b exp=0", bus_write); end
    checks++; if (cpu_mem_busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b exp=1", cpu_mem_busy); end
    bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL load_valid got=%b exp=1", cpu_valid); end
    checks++; if (cpu_rdata !== 32'h1122_3344) begin errors++; $display("FAIL load_rdata got=%h exp=11223344", cpu_rdata); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL load_req_drop got=%b exp=0", bus_req); end
    tick();
    checks++; if ({cpu_valid, cpu_mem_busy} !== 2'b00) begin errors++; $display("FAIL load_idle got=%b%b exp=00", cpu_valid, cpu_mem_busy); end
  endtask

  task automatic test_store_delayed_ack;
    issue(32'h0000_2002, 1'b1, 4'b1100, 32'hABCD_0000);
    checks++; if (bus_addr !== 32'h0000_2000) begin errors++; $display("FAIL store_addr got=%h exp=00002000", bus_addr); end
    checks++; if ({bus_write, bus_wstrb} !== 5'b1_1100) begin errors++; $display("FAIL store_ctrl got=%b%b exp=11100", bus_write, bus_wstrb); end
    checks++; if (bus_wdata !== 32'hABCD_0000) begin errors++; $display("FAIL store_wdata got=%h exp=abcd0000", bus_wdata); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus_req, cpu_valid} !== 2'b10) begin errors++; $display("FAIL store_hold%0d got req=%b valid=%b exp req=1 valid=0", i, bus_req, cpu_valid); end
      if (i == 3) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    checks++; if ({bus_req, cpu_valid} !== 2'b01) begin errors++; $display("FAIL store_done got req=%b valid=%b exp req=0 valid=1", bus_req, cpu_valid); end
    checks++; if (cpu_rdata !== 32'h1122_3344) begin errors++; $display("FAIL store_rdata_kept got=%h exp=11223344", cpu_rdata); end
    tick();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL store_valid_pulse got=%b exp=0", cpu_valid); end
  endtask

  task automatic test_suppressed_store;
    issue(32'h0000_2003, 1'b1, 4'b0000, 32'h1234_5678);
    checks++; if ({bus_req, cpu_valid} !== 2'b01) begin errors++; $display("FAIL supp_n1 got req=%b valid=%b exp req=0 valid=1", bus_req, cpu_valid); end
    checks++; if (cpu_rdata !== 32'h1122_3344) begin errors++; $display("FAIL supp_rdata got=%h exp=11223344", cpu_rdata); end
    tick();
    checks++; if ({bus_req, cpu_valid, cpu_mem_busy} !== 3'b000) begin errors++; $display("FAIL supp_idle got=%b%b%b exp=000", bus_req, cpu_valid, cpu_mem_busy); end
  endtask

  task automatic test_timeout;
    issue(32'h0000_3000, 1'b0, 4'b0000, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      checks++; if ({bus_req, cpu_valid, bus_timeout} !== 3'b100) begin errors++; $display("FAIL to_wait%0d got req=%b valid=%b to=%b exp 1/0/0", k, bus_req, cpu_valid, bus_timeout); end
      tick();
    end
    checks++; if ({bus_req, cpu_valid, bus_timeout} !== 3'b011) begin errors++; $display("FAIL to_fire got req=%b valid=%b to=%b exp 0/1/1", bus_req, cpu_valid, bus_timeout); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata got=%h exp=deadbeef", cpu_rdata); end
    tick();
    checks++; if ({cpu_valid, bus_timeout, cpu_mem_busy} !== 3'b000) begin errors++; $display("FAIL to_after got=%b%b%b exp=000", cpu_valid, bus_timeout, cpu_mem_busy); end
  endtask

  task automatic test_overrun;
    issue(32'h0000_4000, 1'b0, 4'b0000, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if ({bus_req, cpu_mem_busy, err_overrun} !== 3'b010) begin errors++; $display("FAIL ovr_rwait got=%b%b%b exp=010", bus_req, cpu_mem_busy, err_overrun); end
    issue(32'h0000_5000, 1'b0, 4'b0000, 32'h0);
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", err_overrun); end
    checks++; if ({bus_req, bus_addr} !== {1'b0, 32'h0000_4000}) begin errors++; $display("FAIL ovr_unaffected got req=%b addr=%h exp 0/00004000", bus_req, bus_addr); end
    bus_rvalid = 1'b1; bus_rdata = 32'h5566_7788;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    checks++; if ({cpu_valid, cpu_rdata} !== {1'b1, 32'h5566_7788}) begin errors++; $display("FAIL ovr_complete got valid=%b rdata=%h exp 1/55667788", cpu_valid, cpu_rdata); end
    tick(); tick();
    checks++; if ({bus_req, cpu_mem_busy, err_overrun} !== 3'b001) begin errors++; $display("FAIL ovr_sticky got=%b%b%b exp=001", bus_req, cpu_mem_busy, err_overrun); end
  endtask

  task automatic test_reset_mid;
    issue(32'h0000_6000, 1'b0, 4'b0000, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (cpu_mem_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b exp=1", cpu_mem_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({cpu_mem_busy, err_overrun, bus_req} !== 3'b000) begin errors++; $display("FAIL rst_mid_async got=%b%b%b exp=000", cpu_mem_busy, err_overrun, bus_req); end
    checks++; if ({cpu_rdata, bus_addr} !== 64'h0) begin errors++; $display("FAIL rst_mid_regs got rdata=%h addr=%h exp 0/0", cpu_rdata, bus_addr); end
    #2 rst_n = 1'b1;
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h9999_9999;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    checks++; if ({cpu_valid, cpu_mem_busy, cpu_rdata} !== 34'h0) begin errors++; $display("FAIL rst_mid_late got valid=%b busy=%b rdata=%h exp 0/0/0", cpu_valid, cpu_mem_busy, cpu_rdata); end
  endtask

  task automatic test_back_to_back;
    issue(32'h0000_7008, 1'b0, 4'b0000, 32'h0);
    bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5_0001;
    tick();
    bus_ack = 1'b0; bus_rvalid = 1'b0;
    tick();
    issue(32'h0000_700C, 1'b0, 4'b0000, 32'h0);
    checks++; if ({bus_req, bus_addr, err_overrun} !== {1'b1, 32'h0000_700C, 1'b0}) begin errors++; $display("FAIL b2b_second got req=%b addr=%h ovr=%b exp 1/0000700c/0", bus_req, bus_addr, err_overrun); end
    bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5_0002;
    tick();
    bus_ack = 1'b0; bus_rvalid = 1'b0;
    checks++; if ({cpu_valid, cpu_rdata} !== {1'b1, 32'hA5A5_0002}) begin errors++; $display("FAIL b2b_data got valid=%b rdata=%h exp 1/a5a50002", cpu_valid, cpu_rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_delayed_ack();
    test_suppressed_store();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
